// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: ALU op codes, R-type funct codes and issue FSM states shared by the issue stage and the ALU.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_DIV  = 6'h1A;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: upstream op handshake, ALU side-band and downstream response bundle.
interface alu_issue_ctrl_if #(parameter int DATA_W = 32);

    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [4:0]        in_shamt;
    logic              alu_en;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] alu_srcA;
    logic [DATA_W-1:0] alu_srcB;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_hi;
    logic [DATA_W-1:0] alu_lo;
    logic              alu_overflow;
    logic              alu_done;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_wr_rd;
    logic              out_illegal;
    logic              out_timeout;
    logic              out_exc;

    modport master (
        input  in_valid, in_funct, in_rs_data, in_rt_data, in_shamt,
        input  alu_result, alu_hi, alu_lo, alu_overflow, alu_done, out_ready,
        output in_ready, alu_en, alu_control, alu_srcA, alu_srcB,
        output out_valid, out_result, out_wr_rd, out_illegal, out_timeout, out_exc
    );

    modport slave (
        output in_valid, in_funct, in_rs_data, in_rt_data, in_shamt,
        output alu_result, alu_hi, alu_lo, alu_overflow, alu_done, out_ready,
        input  in_ready, alu_en, alu_control, alu_srcA, alu_srcB,
        input  out_valid, out_result, out_wr_rd, out_illegal, out_timeout, out_exc
    );

endinterface

// File: rtl/alu_issue_ctrl_funct_decode.sv
// alu_funct_decode: combinational R-type funct decode into ALU op code and issue-class flags.
module alu_funct_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       is_shift,
    output logic       is_hilo_op,
    output logic       is_local,
    output logic       is_illegal,
    output logic       is_trapping
);

    always_comb begin
        alu_control = ALU_ADD;
        is_illegal  = 1'b0;
        case (funct)
            F_ADD, F_ADDU:  alu_control = ALU_ADD;
            F_SUB, F_SUBU:  alu_control = ALU_SUB;
            F_AND:          alu_control = ALU_AND;
            F_OR:           alu_control = ALU_OR;
            F_NOR:          alu_control = ALU_NOR;
            F_SLT:          alu_control = ALU_SLT;
            F_SLL:          alu_control = ALU_SLL;
            F_SRL:          alu_control = ALU_SRL;
            F_MULT:         alu_control = ALU_MULT;
            F_DIV:          alu_control = ALU_DIV;
            F_MFHI, F_MFLO: alu_control = ALU_ADD;
            default:        is_illegal  = 1'b1;
        endcase
    end

    assign is_shift    = funct == F_SLL || funct == F_SRL;
    assign is_hilo_op  = funct == F_MULT || funct == F_DIV;
    assign is_local    = funct == F_MFHI || funct == F_MFLO;
    // Only the signed forms trap; addu/subu wrap silently.
    assign is_trapping = funct == F_ADD || funct == F_SUB || funct == F_DIV;

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decode/issue stage in front of the ALU with local mfhi/mflo and illegal handling.
// Define ALU_OVF_TRAP_EN to raise out_exc on signed add/sub/div overflow.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DONE_TIMEOUT = 8,
    parameter int DATA_W       = 32
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_ctrl_if.master bus
);

    localparam int CW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(DONE_TIMEOUT - 1);

    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [3:0]        ctrl_q;
    logic [DATA_W-1:0] src_a_q, src_b_q, res_q;
    logic              hilo_q, wr_q, ill_q, to_q;
    logic [3:0]        d_ctrl;
    logic              d_shift, d_hilo, d_local, d_illegal, d_trap;
    logic              accept, trap_ovf;

    alu_funct_decode u_dec (
        .funct       (bus.in_funct),
        .alu_control (d_ctrl),
        .is_shift    (d_shift),
        .is_hilo_op  (d_hilo),
        .is_local    (d_local),
        .is_illegal  (d_illegal),
        .is_trapping (d_trap)
    );

    assign accept = state == IDLE && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) nxt = (d_local || d_illegal) ? RESP : ISSUE;
            ISSUE:   nxt = WAIT;
            WAIT:    if (bus.alu_done || cnt == LAST) nxt = RESP;
            RESP:    if (bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Payload registers double as the response; they are zeroed when the response leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ctrl_q  <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            res_q   <= '0;
            hilo_q  <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= '0;
                ctrl_q  <= d_ctrl;
                src_a_q <= d_shift ? DATA_W'(bus.in_shamt) : bus.in_rs_data;
                src_b_q <= bus.in_rt_data;
                hilo_q  <= d_hilo;
                res_q   <= !d_local ? '0 : bus.in_funct == F_MFHI ? bus.alu_hi : bus.alu_lo;
                wr_q    <= d_local;
                ill_q   <= d_illegal;
            end
            if (state == WAIT) begin
                if (bus.alu_done) begin
                    res_q <= hilo_q ? '0 : bus.alu_result;
                    wr_q  <= !hilo_q && !trap_ovf;
                end else if (cnt == LAST) begin
                    to_q <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (state == RESP && bus.out_ready) begin
                res_q <= '0;
                wr_q  <= 1'b0;
                ill_q <= 1'b0;
                to_q  <= 1'b0;
            end
        end
    end

`ifdef ALU_OVF_TRAP_EN
    logic trap_q, exc_q;

    assign trap_ovf    = trap_q & bus.alu_overflow;
    assign bus.out_exc = exc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
            exc_q  <= 1'b0;
        end else begin
            if (accept) trap_q <= d_trap;
            if (state == WAIT && bus.alu_done) exc_q <= trap_ovf;
            else if (state == RESP && bus.out_ready) exc_q <= 1'b0;
        end
    end
`else
    assign trap_ovf    = 1'b0;
    assign bus.out_exc = 1'b0;
`endif

    assign bus.in_ready    = state == IDLE;
    assign bus.alu_en      = state == ISSUE;
    assign bus.alu_control = ctrl_q;
    assign bus.alu_srcA    = src_a_q;
    assign bus.alu_srcB    = src_b_q;
    assign bus.out_valid   = state == RESP;
    assign bus.out_result  = res_q;
    assign bus.out_wr_rd   = wr_q;
    assign bus.out_illegal = ill_q;
    assign bus.out_timeout = to_q;

    a_en_pulse: assert property (@(posedge clk) disable iff (!rst_n) bus.alu_en |=> !bus.alu_en);
    a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_result) && $stable(bus.out_wr_rd));
    a_ops_stable: assert property (@(posedge clk) disable iff (!rst_n)
        state == ISSUE |=> $stable(bus.alu_control) && $stable(bus.alu_srcA) && $stable(bus.alu_srcB));

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Decode/issue stage sitting directly upstream of the ALU.
- Accepts one R-type operation per handshake: funct, register operands and shamt.
- Translates funct to the ALU's 4-bit control code and drives its en/srcA/srcB. Waits for alu_done, then presents the captured result downstream on a valid/ready handshake.
- mfhi/mflo and illegal functs are serviced locally without issuing to the ALU.

Parameters:
- DONE_TIMEOUT, 8, max cycles in WAIT for alu_done before aborting with out_timeout.
- DATA_W, 32, operand/result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  high only in IDLE.
- in_funct  in  6  MIPS R-type funct field.
- in_rs_data  in  DATA_W  $rs value.
- in_rt_data  in  DATA_W  $rt value.
- in_shamt  in  5  shift amount.
- alu_en  out  1  ALU enable, one-cycle pulse.
- alu_control  out  4  ALU op code.
- alu_srcA  out  DATA_W  rs, or zero-extended shamt for shifts.
- alu_srcB  out  DATA_W  rt.
- alu_result  in  DATA_W  ALU result.
- alu_hi  in  DATA_W  ALU HI.
- alu_lo  in  DATA_W  ALU LO.
- alu_overflow  in  1  ALU overflow/div-by-zero flag.
- alu_done  in  1  ALU completion flag (may stay high; treated as a level).
- out_valid  out  1  response valid.
- out_ready  in  1  downstream accepts response.
- out_result  out  DATA_W  value to write to $rd.
- out_wr_rd  out  1  out_result must be written to $rd.
- out_illegal  out  1  funct not supported.
- out_timeout  out  1  alu_done not seen within DONE_TIMEOUT.
- out_exc  out  1  arithmetic exception (see Optional Feature).

Behaviour:
- Reset: FSM=IDLE. All outputs 0 except in_ready=1. Timeout counter and operand registers cleared.
- Reset mid-operation returns to IDLE immediately. Any late ALU completion is ignored.
- Funct decode (ALU code):
  - 0x20/0x21 → ADD 0000
  - 0x22/0x23 → SUB 0001
  - 0x24 → AND 0010
  - 0x25 → OR 0011
  - 0x27 → NOR 0100
  - 0x2A → SLT 0101
  - 0x00 → SLL 0110
  - 0x02 → SRL 0111
  - 0x18 → MULT 1000
  - 0x1A → DIV 1001
  - 0x10 = mfhi, 0x12 = mflo (local).
  - Anything else is illegal.
- Source select: for SLL/SRL, alu_srcA = {27'b0, shamt}. Otherwise alu_srcA = rs. alu_srcB = rt always.
- States and transitions:
  - IDLE: on accept (in_valid & in_ready) at cycle T, latch funct/operands.
    - ALU ops → ISSUE.
    - mfhi/mflo → RESP, out_result = alu_hi/alu_lo sampled at T, out_wr_rd = 1.
    - Illegal → RESP, out_illegal = 1, out_wr_rd = 0, out_result = 0.
  - ISSUE (T+1): alu_en = 1 for exactly this cycle. alu_control/srcA/srcB come from registers and stay stable through ISSUE and WAIT. → WAIT.
  - WAIT (T+2 onward): when alu_done = 1, capture alu_result and alu_overflow → RESP.
    - out_wr_rd = 1 except for MULT/DIV, which give 0 and out_result = 0.
    - Counter increments each WAIT cycle. On reaching DONE_TIMEOUT → RESP with out_timeout = 1, out_wr_rd = 0.
  - RESP: out_valid = 1, payload held stable until out_ready. On out_valid & out_ready → IDLE. Flags clear on exit.
- Latency:
  - Best-case ALU op: out_valid at T+3.
  - Local op: out_valid at T+1.
  - Throughput: one op per 4 cycles (2 for local ops) with out_ready tied high.
- No new accept while not IDLE; in_ready = 0 in ISSUE/WAIT/RESP.
- alu_done already high from a prior op is valid only from WAIT onward. It is never sampled in ISSUE.

Optional Feature:
- Macro ALU_OVF_TRAP_EN.
- Defined: alu_overflow captured for funct 0x20, 0x22 or 0x1A sets out_exc = 1 and forces out_wr_rd = 0. addu/subu never trap.
- Undefined: out_exc tied 0, alu_overflow ignored, out_wr_rd unaffected.

Decomposition:
- Shared package holds:
  - ALU op code constants (0000–1001), shared with the ALU.
  - funct constants.
  - FSM state enum {IDLE, ISSUE, WAIT, RESP}.
- One natural sub-module: alu_funct_decode (combinational funct → alu_control, is_shift, is_hilo_op, is_local, is_illegal, is_trapping).

Test Plan:
- add: rs=5, rt=7, funct=0x20 → alu_en pulses once at T+1 with control 0000, srcA=5, srcB=7. ALU returns 12 → out_valid at T+3, out_result=12, out_wr_rd=1.
- sll: rt=0x1, shamt=4, funct=0x00 → srcA=0x4, control 0110, out_result=0x10. srl with rt=0x80000000, shamt=31 → out_result=1.
- mult: 0x10000 × 0x10000, then mfhi/mflo → mult response out_wr_rd=0. mfhi out_result=1 and mflo out_result=0, each with out_valid at T+1 and no alu_en.
- Illegal funct 0x3F → out_illegal=1, out_wr_rd=0, no alu_en. alu_done held low for an ALU op with DONE_TIMEOUT=8 → out_timeout=1 after 8 WAIT cycles.
- Backpressure: out_ready low for 5 cycles in RESP → payload stable, in_ready=0. Assert rst_n=0 during WAIT → all outputs 0, in_ready=1 asynchronously.
- ALU_OVF_TRAP_EN: add with ALU overflow=1 → out_exc=1, out_wr_rd=0. addu with overflow=1 → out_exc=0, out_wr_rd=1. Macro undefined → out_exc=0 in both cases.
